// File: rtl/armleocpu_f2e_queue_pkg.sv
// Shared definitions for the fetch-to-execute instruction queue:
// privilege codes, the NOP encoding and the stored packet layout.
package armleocpu_f2e_queue_pkg;

  localparam logic [1:0] ARMLEOCPU_PRIVILEGE_USER       = 2'b00;
  localparam logic [1:0] ARMLEOCPU_PRIVILEGE_SUPERVISOR = 2'b01;
  localparam logic [1:0] ARMLEOCPU_PRIVILEGE_MACHINE    = 2'b11;

  localparam logic [31:0] armleocpu_instruction_nop = 32'h0000_0013;

  localparam int F2E_PKT_W = 32 + 32 + 1 + 32 + 32 + 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc_start;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [1:0]  exc_privilege;
  } f2e_pkt_t;

endpackage

// File: rtl/armleocpu_f2e_queue_mem.sv
// Packet storage for the f2e queue: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module armleocpu_f2e_queue_mem
  import armleocpu_f2e_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [PTR_W-1:0]     waddr_i,
  input  logic [F2E_PKT_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]     raddr_i,
  output logic [F2E_PKT_W-1:0] rdata_o
);

  logic [F2E_PKT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/armleocpu_f2e_queue.sv
// Instruction queue between fetch and execute: in-order buffering of fetch
// packets, redirect flush, and a barrier that blocks fetch behind an exception entry.
module armleocpu_f2e_queue
  import armleocpu_f2e_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             f_valid,
  input  logic [31:0]      f_instr,
  input  logic [31:0]      f_pc,
  input  logic             f_exc_start,
  input  logic [31:0]      f_epc,
  input  logic [31:0]      f_cause,
  input  logic [1:0]       f_exc_privilege,
  output logic             f_ready,

  output logic             e_valid,
  output logic [31:0]      e_instr,
  output logic [31:0]      e_pc,
  output logic             e_exc_start,
  output logic [31:0]      e_epc,
  output logic [31:0]      e_cause,
  output logic [1:0]       e_exc_privilege,
  input  logic             e_ready,
  input  logic             e_flush,

  output logic [PTR_W:0]   occupancy
);

  localparam logic [PTR_W:0]   CNT_FULL = PTR_W'(0) | (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             barrier_q, barrier_d;

  logic     push, pop;
  f2e_pkt_t wr_pkt, rd_pkt;

  assign wr_pkt = '{instr:         f_instr,
                    pc:            f_pc,
                    exc_start:     f_exc_start,
                    epc:           f_epc,
                    cause:         f_cause,
                    exc_privilege: f_exc_privilege};

  armleocpu_f2e_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_pkt),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_pkt)
  );

  // A full queue refuses even when execute is popping, keeping e_ready off this path.
  assign f_ready = !rst && (count_q != CNT_FULL) && !barrier_q;
  assign e_valid = !rst && (count_q != '0);

  assign push = f_valid && f_ready && !e_flush;
  assign pop  = e_valid && e_ready && !e_flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    barrier_d = barrier_q;
    if (e_flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      barrier_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
      // Only one exception entry can be queued, so popping any one releases the barrier.
      if (push && f_exc_start)          barrier_d = 1'b1;
      else if (pop && rd_pkt.exc_start) barrier_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      barrier_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      barrier_q <= barrier_d;
    end
  end

  assign e_instr         = e_valid ? rd_pkt.instr         : armleocpu_instruction_nop;
  assign e_pc            = e_valid ? rd_pkt.pc            : '0;
  assign e_exc_start     = e_valid ? rd_pkt.exc_start     : 1'b0;
  assign e_epc           = e_valid ? rd_pkt.epc           : '0;
  assign e_cause         = e_valid ? rd_pkt.cause         : '0;
  assign e_exc_privilege = e_valid ? rd_pkt.exc_privilege : '0;

  assign occupancy = count_q;

endmodule

// File: tb/tb_armleocpu_f2e_queue.sv
// Scoreboard bench for armleocpu_f2e_queue: directed scenarios followed by
// random traffic, checked against a queue-based reference model.
module tb_armleocpu_f2e_queue;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [1:0]  priv;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_valid = 1'b0;
  logic [31:0] f_instr = '0;
  logic [31:0] f_pc = '0;
  logic        f_exc_start = 1'b0;
  logic [31:0] f_epc = '0;
  logic [31:0] f_cause = '0;
  logic [1:0]  f_exc_privilege = '0;
  logic        f_ready;
  logic        e_valid;
  logic [31:0] e_instr, e_pc, e_epc, e_cause;
  logic        e_exc_start;
  logic [1:0]  e_exc_privilege;
  logic        e_ready = 1'b0;
  logic        e_flush = 1'b0;
  logic [1:0]  occupancy;

  armleocpu_f2e_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .f_valid         (f_valid),
    .f_instr         (f_instr),
    .f_pc            (f_pc),
    .f_exc_start     (f_exc_start),
    .f_epc           (f_epc),
    .f_cause         (f_cause),
    .f_exc_privilege (f_exc_privilege),
    .f_ready         (f_ready),
    .e_valid         (e_valid),
    .e_instr         (e_instr),
    .e_pc            (e_pc),
    .e_exc_start     (e_exc_start),
    .e_epc           (e_epc),
    .e_cause         (e_cause),
    .e_exc_privilege (e_exc_privilege),
    .e_ready         (e_ready),
    .e_flush         (e_flush),
    .occupancy       (occupancy)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  pkt_t exp_q[$];
  bit   model_barrier = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] pc, input bit exc,
                              input logic [31:0] epc, input logic [31:0] cause);
    pkt_t p;
    p.instr = pc ^ 32'hA5A5_0000;
    p.pc    = pc;
    p.exc   = exc;
    p.epc   = epc;
    p.cause = cause;
    p.priv  = exc ? 2'b11 : 2'b00;
    return p;
  endfunction

  // One cycle: drive at negedge, check f_ready, update the model at posedge.
  task automatic drive(input bit fv, input bit er, input bit fl, input bit r, input pkt_t p);
    bit exp_ready, do_push, pop_exc;
    @(negedge clk);
    rst = r; f_valid = fv; e_ready = er; e_flush = fl;
    f_instr = p.instr; f_pc = p.pc; f_exc_start = p.exc;
    f_epc = p.epc; f_cause = p.cause; f_exc_privilege = p.priv;
    #1;
    exp_ready = !r && (exp_q.size() != DEPTH) && !model_barrier;
    chk("f_ready", 32'(f_ready), 32'(exp_ready));
    do_push = fv && exp_ready && !fl;
    pop_exc = !r && !fl && er && (exp_q.size() != 0) && exp_q[0].exc;
    @(posedge clk);
    if (r || fl) begin
      exp_q.delete();
      model_barrier = 1'b0;
    end else begin
      if (do_push) begin
        exp_q.push_back(p);
        if (p.exc) model_barrier = 1'b1;
      end
      if (pop_exc) model_barrier = 1'b0;
    end
  endtask

  // Monitor: compares the presented head against the model every cycle and
  // retires the model head whenever execute consumes it.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
      chk("e_valid", 32'(e_valid), 32'(!rst && exp_q.size() != 0));
      if (!rst && exp_q.size() != 0) begin
        chk("e_instr", e_instr, exp_q[0].instr);
        chk("e_pc", e_pc, exp_q[0].pc);
        chk("e_exc_start", 32'(e_exc_start), 32'(exp_q[0].exc));
        chk("e_epc", e_epc, exp_q[0].epc);
        chk("e_cause", e_cause, exp_q[0].cause);
        chk("e_exc_privilege", 32'(e_exc_privilege), 32'(exp_q[0].priv));
        if (!e_flush && e_ready) void'(exp_q.pop_front());
      end else if (!rst) begin
        chk("empty_instr_nop", e_instr, NOP);
        chk("empty_fields_zero", e_pc | e_epc | e_cause | 32'(e_exc_start) | 32'(e_exc_privilege), 32'h0);
      end
    end
  end

  pkt_t idle;

  initial begin
    idle = mk(32'h0, 1'b0, 32'h0, 32'h0);

    // Reset then idle
    drive(0, 0, 0, 1, idle);
    drive(0, 0, 0, 1, idle);
    drive(0, 0, 0, 0, idle);
    #1;
    chk("idle_f_ready", 32'(f_ready), 32'h1);
    chk("idle_e_instr", e_instr, NOP);
    chk("idle_occupancy", 32'(occupancy), 32'h0);

    // Fill then drain
    drive(1, 0, 0, 0, mk(32'h2000, 0, 0, 0));
    drive(1, 0, 0, 0, mk(32'h2004, 0, 0, 0));
    #1;
    chk("full_occupancy", 32'(occupancy), 32'h2);
    chk("full_f_ready", 32'(f_ready), 32'h0);
    chk("full_head_pc", e_pc, 32'h2000);
    drive(0, 1, 0, 0, idle);
    #1;
    chk("drain_second_pc", e_pc, 32'h2004);
    drive(0, 1, 0, 0, idle);
    #1;
    chk("drained_e_valid", 32'(e_valid), 32'h0);

    // Streaming across pointer wrap
    for (int k = 0; k < 10; k++) drive(1, 1, 0, 0, mk(32'h2000 + 32'(4 * k), 0, 0, 0));
    #1;
    chk("stream_occupancy", 32'(occupancy), 32'h1);
    drive(0, 1, 0, 0, idle);

    // Flush with a concurrent push
    drive(1, 0, 0, 0, mk(32'h2100, 0, 0, 0));
    drive(1, 0, 0, 0, mk(32'h2104, 0, 0, 0));
    drive(1, 1, 1, 0, mk(32'h3000, 0, 0, 0));
    #1;
    chk("flush_occupancy", 32'(occupancy), 32'h0);
    chk("flush_e_valid", 32'(e_valid), 32'h0);
    drive(0, 0, 0, 0, idle);

    // Exception barrier
    drive(1, 0, 0, 0, mk(32'h2200, 1, 32'h2008, 32'h2));
    drive(1, 0, 0, 0, mk(32'h2204, 0, 0, 0));
    #1;
    chk("barrier_f_ready", 32'(f_ready), 32'h0);
    chk("barrier_e_cause", e_cause, 32'h2);
    chk("barrier_e_epc", e_epc, 32'h2008);
    drive(0, 1, 0, 0, idle);
    #1;
    chk("barrier_release_f_ready", 32'(f_ready), 32'h1);

    // Reset mid-stream
    drive(1, 0, 0, 0, mk(32'h2300, 0, 0, 0));
    drive(0, 1, 0, 1, idle);
    #1;
    chk("midreset_occupancy", 32'(occupancy), 32'h0);
    drive(0, 0, 0, 0, idle);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      pkt_t p;
      p.instr = $urandom();
      p.pc    = $urandom();
      p.exc   = ($urandom_range(7) == 0);
      p.epc   = $urandom();
      p.cause = $urandom();
      p.priv  = 2'($urandom_range(3));
      drive(($urandom_range(3) != 0), ($urandom_range(2) != 0),
            ($urandom_range(15) == 0), ($urandom_range(63) == 0), p);
    end

    drive(0, 0, 0, 0, idle);
    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
